// File: rtl/a_format_decode_queue.sv
// -----------------------------------------------------------------------------
// a_format_decode_queue
//
// Decodes A-form floating-point arithmetic instructions (primary 59/63), fsel
// and isel into micro-ops and buffers them in a small first-word-fall-through
// queue. Record-form FP instructions (Rc=1) can optionally be cracked into a
// second micro-op that updates CR1. Unsupported instructions are consumed and
// flagged with a one-cycle illegal pulse; nothing is queued for them.
//
// Ports
//   clock_i, reset_i        clock, asynchronous active-high reset
//   flush_i                 synchronous clear of queue and crack state
//   enable_i / ready_o      instruction valid / block can accept this cycle
//   instruction_i[0:31]     instruction word, big-endian bit numbering
//   instruction*_i, is64Bit_i  side-band carried unchanged into the micro-op
//   stall_i                 downstream backpressure (head is held)
//   enable_o                queue head valid
//   illegal_o               pulse the cycle after an unsupported instruction
//   opcode_o                {primary[0:5], XO[0:4], Rc}
//   functionalUnitType_o    FX / FP / CR unit code
//   instMajId_o/instMinId_o major ID and micro-op index within the instruction
//   opNrw_o[0:1]            [0]=read, [1]=write; opNIsReg_o operand is a register
//   instructionBody_o       {bits 6:10, 11:15, 16:20, 21:25}
// All head outputs read as zero while enable_o is low.
// -----------------------------------------------------------------------------
module a_format_decode_queue #(
    parameter int unsigned QueueDepth              = 4,
    parameter int unsigned CrackRecordForm         = 1,
    parameter int unsigned addressWidth            = 64,
    parameter int unsigned PidSize                 = 20,
    parameter int unsigned TidSize                 = 16,
    parameter int unsigned instructionCounterWidth = 64,
    parameter int unsigned instMinIdWidth          = 7,
    parameter int unsigned regSize                 = 5,
    parameter logic [2:0]  FXUnitId                = 3'd0,
    parameter logic [2:0]  FPUnitId                = 3'd1,
    parameter logic [2:0]  CRUnitId                = 3'd3
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               flush_i,
    input  logic                               enable_i,
    output logic                               ready_o,
    input  logic [0:31]                        instruction_i,
    input  logic [addressWidth-1:0]            instructionAddress_i,
    input  logic                               is64Bit_i,
    input  logic [PidSize-1:0]                 instructionPid_i,
    input  logic [TidSize-1:0]                 instructionTid_i,
    input  logic [instructionCounterWidth-1:0] instructionMajId_i,
    input  logic                               stall_i,
    output logic                               enable_o,
    output logic                               illegal_o,
    output logic [11:0]                        opcode_o,
    output logic [2:0]                         functionalUnitType_o,
    output logic [instructionCounterWidth-1:0] instMajId_o,
    output logic [instMinIdWidth-1:0]          instMinId_o,
    output logic [addressWidth-1:0]            instructionAddress_o,
    output logic                               is64Bit_o,
    output logic [PidSize-1:0]                 instPid_o,
    output logic [TidSize-1:0]                 instTid_o,
    output logic [0:1]                         op1rw_o,
    output logic [0:1]                         op2rw_o,
    output logic [0:1]                         op3rw_o,
    output logic [0:1]                         op4rw_o,
    output logic                               op1IsReg_o,
    output logic                               op2IsReg_o,
    output logic                               op3IsReg_o,
    output logic                               op4IsReg_o,
    output logic [4*regSize-1:0]               instructionBody_o
);

    localparam int unsigned PtrW = $clog2(QueueDepth);
    localparam int unsigned CntW = PtrW + 1;

    // Operand access codes are written left-to-right as [0:1], so 2'b01 is a
    // pure write and 2'b10 a pure read.
    localparam logic [0:1] RW_NONE  = 2'b00;
    localparam logic [0:1] RW_READ  = 2'b10;
    localparam logic [0:1] RW_WRITE = 2'b01;

    typedef struct packed {
        logic [11:0]                        opcode;
        logic [2:0]                         fu;
        logic [instructionCounterWidth-1:0] maj_id;
        logic [instMinIdWidth-1:0]          min_id;
        logic [addressWidth-1:0]            addr;
        logic                               is64;
        logic [PidSize-1:0]                 pid;
        logic [TidSize-1:0]                 tid;
        logic [1:4][0:1]                    op_rw;
        logic [1:4]                         op_is_reg;
        logic [4*regSize-1:0]               body;
    } uop_t;

    typedef enum logic {
        ST_IDLE,
        ST_CRACK
    } state_e;

    // -------------------------------------------------------------------------
    // Instruction field extraction and classification
    // -------------------------------------------------------------------------
    logic [5:0] primary;
    logic [4:0] xo;
    logic       rc;
    logic [4:0] ra;
    logic       is_fp_prim;
    logic       is_fp_arith;
    logic       is_fsel;
    logic       is_isel;
    logic       is_fp;
    logic       is_legal;
    logic       needs_crack;

    assign primary = instruction_i[0:5];
    assign xo      = instruction_i[26:30];
    assign rc      = instruction_i[31];
    assign ra      = instruction_i[11:15];

    assign is_fp_prim  = (primary == 6'd59) || (primary == 6'd63);
    assign is_fp_arith = is_fp_prim &&
                         (xo inside {5'd18, 5'd20, 5'd21, 5'd22, 5'd24, 5'd25,
                                     5'd26, 5'd28, 5'd29, 5'd30, 5'd31});
    assign is_fsel     = (primary == 6'd63) && (xo == 5'd23);
    assign is_isel     = (primary == 6'd31) && (xo == 5'd15);
    assign is_fp       = is_fp_arith || is_fsel;
    assign is_legal    = is_fp || is_isel;
    // isel ignores Rc, so only FP forms are ever cracked.
    assign needs_crack = is_fp && rc && (CrackRecordForm != 0);

    // -------------------------------------------------------------------------
    // Micro-op construction
    // -------------------------------------------------------------------------
    uop_t main_uop;
    uop_t cr_uop;

    // NOTE: every variable assigned in an always_comb gets a default on entry,
    // so no path through the case/if tree can leave it holding a stale value
    // (which would infer a latch).
    always_comb begin
        main_uop              = '0;
        main_uop.opcode       = {primary, xo, rc};
        main_uop.maj_id       = instructionMajId_i;
        main_uop.addr         = instructionAddress_i;
        main_uop.is64         = is64Bit_i;
        main_uop.pid          = instructionPid_i;
        main_uop.tid          = instructionTid_i;
        main_uop.body         = instruction_i[6:25];
        main_uop.op_rw[1]     = RW_WRITE;
        main_uop.op_is_reg[1] = 1'b1;

        if (is_isel) begin
            // RA=0 means the literal value zero rather than GPR0; BC sits in the
            // body and is not a register operand.
            main_uop.fu           = FXUnitId;
            main_uop.op_rw[2]     = RW_READ;
            main_uop.op_is_reg[2] = (ra != 5'd0);
            main_uop.op_rw[3]     = RW_READ;
            main_uop.op_is_reg[3] = 1'b1;
        end else begin
            main_uop.fu = FPUnitId;
            case (xo)
                5'd18, 5'd20, 5'd21: begin // fdiv / fsub / fadd: FRA, FRB
                    main_uop.op_rw[2]     = RW_READ;
                    main_uop.op_is_reg[2] = 1'b1;
                    main_uop.op_rw[3]     = RW_READ;
                    main_uop.op_is_reg[3] = 1'b1;
                end
                5'd25: begin               // fmul: FRA, FRC
                    main_uop.op_rw[2]     = RW_READ;
                    main_uop.op_is_reg[2] = 1'b1;
                    main_uop.op_rw[4]     = RW_READ;
                    main_uop.op_is_reg[4] = 1'b1;
                end
                5'd22, 5'd24, 5'd26: begin // fsqrt / fre / frsqrte: FRB only
                    main_uop.op_rw[3]     = RW_READ;
                    main_uop.op_is_reg[3] = 1'b1;
                end
                default: begin             // fused multiply-add family, fsel
                    main_uop.op_rw[2]     = RW_READ;
                    main_uop.op_is_reg[2] = 1'b1;
                    main_uop.op_rw[3]     = RW_READ;
                    main_uop.op_is_reg[3] = 1'b1;
                    main_uop.op_rw[4]     = RW_READ;
                    main_uop.op_is_reg[4] = 1'b1;
                end
            endcase
        end
    end

    // The CR micro-op shares the opcode and side-band of its parent; only the
    // CR field number (1) is carried in the body, the other fields are zero.
    always_comb begin
        cr_uop                        = main_uop;
        cr_uop.fu                     = CRUnitId;
        cr_uop.min_id                 = instMinIdWidth'(1);
        cr_uop.op_rw                  = '0;
        cr_uop.op_rw[1]               = RW_WRITE;
        cr_uop.op_is_reg              = 4'b1000;
        cr_uop.body                   = '0;
        cr_uop.body[4*regSize-1 -: regSize] = regSize'(1);
    end

    // -------------------------------------------------------------------------
    // Queue control
    // -------------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            illegal_q, illegal_d;
    uop_t            pend_q, pend_d;
    uop_t            mem_q [QueueDepth];

    logic            accept;
    logic            push;
    logic            pop;
    uop_t            push_uop;

    // Two free entries are required so a cracked instruction always has room
    // for its CR micro-op on the following edge, even if the head is stalled.
    assign ready_o  = (state_q == ST_IDLE) &&
                      (count_q <= CntW'(QueueDepth - 2)) && !flush_i;
    assign accept   = enable_i && ready_o;
    assign enable_o = (count_q != '0);
    assign pop      = enable_o && !stall_i && !flush_i;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        illegal_d = 1'b0;
        pend_d    = pend_q;
        push      = 1'b0;
        push_uop  = main_uop;

        if (flush_i) begin
            // Flush wins over everything, including a pending CR micro-op.
            state_d  = ST_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_legal) begin
                            push = 1'b1;
                            if (needs_crack) begin
                                state_d = ST_CRACK;
                                pend_d  = cr_uop;
                            end
                        end else begin
                            illegal_d = 1'b1;
                        end
                    end
                end
                ST_CRACK: begin
                    push     = 1'b1;
                    push_uop = pend_q;
                    state_d  = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase

            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its peers regardless of statement order.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
            pend_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
            pend_q    <= pend_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; entries are only ever
    // observed through the count/pointers, which are reset, and leaving the
    // array out of reset keeps it mappable onto plain flops or RAM.
    always_ff @(posedge clock_i) begin
        if (push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_uop;
        end
    end

    // -------------------------------------------------------------------------
    // Head outputs, forced to zero while the queue is empty
    // -------------------------------------------------------------------------
    uop_t head;

    assign head = enable_o ? mem_q[rd_ptr_q] : '0;

    assign illegal_o            = illegal_q;
    assign opcode_o             = head.opcode;
    assign functionalUnitType_o = head.fu;
    assign instMajId_o          = head.maj_id;
    assign instMinId_o          = head.min_id;
    assign instructionAddress_o = head.addr;
    assign is64Bit_o            = head.is64;
    assign instPid_o            = head.pid;
    assign instTid_o            = head.tid;
    assign op1rw_o              = head.op_rw[1];
    assign op2rw_o              = head.op_rw[2];
    assign op3rw_o              = head.op_rw[3];
    assign op4rw_o              = head.op_rw[4];
    assign op1IsReg_o           = head.op_is_reg[1];
    assign op2IsReg_o           = head.op_is_reg[2];
    assign op3IsReg_o           = head.op_is_reg[3];
    assign op4IsReg_o           = head.op_is_reg[4];
    assign instructionBody_o    = head.body;

endmodule

// File: doc/a_format_decode_queue.md
A_FORMAT_DECODE_QUEUE -- requirements
Module: a_format_decode_queue

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high: clock_i, reset_i.
REQ-002 Parameter QueueDepth, 4, micro-op queue entries (power of 2, >=2).
REQ-003 Parameter CrackRecordForm, 1, 1 = Rc=1 instructions emit an extra CR micro-op.
REQ-004 Parameter addressWidth, 64, instruction address width.
REQ-005 Parameter PidSize / TidSize, 20 / 16, process / thread ID widths.
REQ-006 Parameter instructionCounterWidth, 64, major ID width.
REQ-007 Parameter instMinIdWidth, 7, minor ID width.
REQ-008 Parameter regSize, 5, register field width.
REQ-009 Parameters FXUnitId / FPUnitId / CRUnitId, 0 / 1 / 3, functional unit codes (3 bits).
REQ-010 Ports clock_i, reset_i: in, 1 each, clock and async reset.
REQ-011 flush_i  in  1  synchronous queue and crack-state clear.
REQ-012 enable_i  in  1  input instruction valid.
REQ-013 ready_o  out  1  block can accept an instruction this cycle.
REQ-014 instruction_i  in  32  instruction word, big-endian bits [0:31].
REQ-015 instructionAddress_i / is64Bit_i / instructionPid_i / instructionTid_i / instructionMajId_i  in  per parameters  side-band carried unchanged.
REQ-016 stall_i  in  1  downstream backpressure.
REQ-017 enable_o  out  1  queue head valid.
REQ-018 illegal_o  out  1  one-cycle pulse for a consumed unsupported instruction.
REQ-019 opcode_o  out  12  {primary[0:5], XO[0:4], Rc}.
REQ-020 functionalUnitType_o  out  3; instMajId_o, instMinId_o, instructionAddress_o, is64Bit_o, instPid_o, instTid_o  out  per parameters.
REQ-021 op1rw_o..op4rw_o  out  2 each  [0]=read, [1]=write; op1IsReg_o..op4IsReg_o  out  1 each.
REQ-022 instructionBody_o  out  4*regSize  {bits 6:10, 11:15, 16:20, 21:25}.

Function
REQ-023 Accept SHALL occur on edge where enable_i && ready_o; ready_o = state IDLE && free entries >=2 && !flush_i.
REQ-024 Supported: primary 59/63 XO 18,20,21,22,24,25,26,28,29,30,31; primary 63 XO 23 (fsel); primary 31 XO 15 (isel); all else illegal: consumed, illegal_o high next cycle, nothing queued.
REQ-025 FP main micro-op: unit FPUnitId, op1 write; add/sub/div op2,op3 read, op4 IsReg=0; mul op2,op4 read, op3 IsReg=0; sqrt/re/rsqrte op3 read only; fma/fsel op2-4 read.
REQ-026 isel: unit FXUnitId, op1 write, op2 read with IsReg = (RA!=0), op3 read, op4 IsReg=0 (BC in body), Rc ignored, never cracked.
REQ-027 Main micro-op SHALL be written at accept edge with instMinId_o=0; first-word fall-through, enable_o high the cycle after accept.
REQ-028 FP with Rc=1 and CrackRecordForm=1: state IDLE->CRACK at accept; next edge writes CR micro-op (unit CRUnitId, minor ID 1, op1 IsReg=1 write, op1 body field=1 (CR1), op2-4 IsReg=0, same major ID/address) and returns to IDLE.
REQ-029 Pop on edge where enable_o && !stall_i; simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo QueueDepth.
REQ-030 Outputs SHALL reflect queue head only; all outputs zero when enable_o=0.
REQ-031 flush_i SHALL take priority over push/pop/crack: next edge queue empty, state IDLE, pending CR micro-op discarded.

Reset
REQ-032 Asserting reset_i SHALL immediately empty queue, state IDLE, enable_o=0, illegal_o=0, all outputs 0, ready_o=1 after deassertion; mid-crack reset discards pending CR micro-op.

Verification
REQ-033 fadd FRT=14,FRA=21,FRB=10 (op 63 XO 21 Rc 0), stall_i=0 -> one micro-op, opcode_o={63,21,0}, unit 1, op1rw=01, op4IsReg=0.
REQ-034 fmadds Rc=1 -> two consecutive micro-ops, minor IDs 0 then 1, second unit 3; ready_o low in CRACK cycle.
REQ-035 stall_i held, QueueDepth=4, feed fadds Rc=0 -> ready_o drops after 3 accepts; release stall -> queue drains in order, major IDs preserved.
REQ-036 primary 0 XO 0 -> illegal_o one cycle, enable_o stays 0; isel RA=0 -> op2IsReg_o=0.
REQ-037 reset_i asserted during CRACK and flush_i with 2 entries queued -> enable_o=0 next observation, no CR micro-op appears.
